// File: rtl/writeback_arbiter_if.sv
// Write-back bus: ALU/memory request channels, register bank write port and
// the pending-lookup port used by hazard logic.
`timescale 1ns/1ps
interface writeback_arbiter_if #(
  parameter int Index_size = 4,
  parameter int width      = 32
);
  logic                  mem_valid;
  logic [Index_size-1:0] mem_rd;
  logic [width-1:0]      mem_data;
  logic                  alu_valid;
  logic [Index_size-1:0] alu_rd;
  logic [width-1:0]      alu_data;
  logic                  in_ready;
  logic                  WE;
  logic [Index_size-1:0] Rd;
  logic [width-1:0]      WD;
  logic [Index_size-1:0] chk_reg;
  logic                  chk_pending;
  logic                  empty;

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, chk_reg,
    output in_ready, WE, Rd, WD, chk_pending, empty
  );
  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, chk_reg,
    input  in_ready, WE, Rd, WD, chk_pending, empty
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and memory write-backs into a program-ordered FIFO that drains
// one register-bank write per cycle, with a pending-write lookup for hazards.
`timescale 1ns/1ps
module writeback_arbiter #(
  parameter int Index_size = 4,
  parameter int width      = 32,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               rst,
  writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [Index_size-1:0] rd;
    logic [width-1:0]      data;
  } wb_ent_t;

  wb_ent_t               fifo [DEPTH];
  logic [PW:0]           count;
  logic [PW-1:0]         rd_ptr, wr_ptr, alu_slot;
  logic                  in_ready, mem_acc, alu_acc, deq;
  logic [1:0]            enq_n;
  logic                  we_q;
  logic [Index_size-1:0] rd_q;
  logic [width-1:0]      wd_q;
  logic [DEPTH-1:0]      hit;

  // Ready looks only at the registered count, so two enqueues always fit.
  assign in_ready = (count <= (PW+1)'(DEPTH-2));
  assign mem_acc  = bus.mem_valid && in_ready && (bus.mem_rd != '0);
  assign alu_acc  = bus.alu_valid && in_ready && (bus.alu_rd != '0);
  assign enq_n    = 2'(mem_acc) + 2'(alu_acc);
  assign deq      = (count != '0);
  assign alu_slot = wr_ptr + PW'(mem_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      we_q   <= 1'b0;
      rd_q   <= '0;
      wd_q   <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(enq_n);
      count  <= count + (PW+1)'(enq_n) - (PW+1)'(deq);
      if (deq) begin
        we_q   <= 1'b1;
        rd_q   <= fifo[rd_ptr].rd;
        wd_q   <= fifo[rd_ptr].data;
        rd_ptr <= rd_ptr + 1'b1;
      end else begin
        we_q   <= 1'b0;
      end
    end
  end

  // Storage needs no reset: liveness comes from count/rd_ptr alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (mem_acc) fifo[wr_ptr]   <= '{rd: bus.mem_rd, data: bus.mem_data};
      if (alu_acc) fifo[alu_slot] <= '{rd: bus.alu_rd, data: bus.alu_data};
    end
  end

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_hit
      logic [PW-1:0] off;
      assign off    = PW'(i) - rd_ptr;
      assign hit[i] = ({1'b0, off} < count) && (fifo[i].rd == bus.chk_reg);
    end
  endgenerate

  assign bus.in_ready    = in_ready;
  assign bus.WE          = we_q;
  assign bus.Rd          = rd_q;
  assign bus.WD          = wd_q;
  assign bus.chk_pending = (bus.chk_reg != '0) &&
                           ((|hit) || (we_q && (rd_q == bus.chk_reg)));
  assign bus.empty       = (count == '0) && !we_q;
endmodule
